fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction index, captures the returned
// word into the IF/ID register, and handles redirects, decode back-pressure and halt.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int unsigned MEM_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic [31:0] program_counter,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] DEPTH       = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_IDX    = 32'(MEM_DEPTH - 1);
    localparam logic        RST_HALTED  = (PC_RESET >= DEPTH);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;
    logic        stall;

    // A held word only blocks fetch when there is actually something waiting.
    assign stall = valid_q && !id_ready;

    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        idpc_d   = idpc_q;
        halted_d = halted_q;
        count_d  = count_q;
        if (branch_taken) begin
            pc_d     = branch_target;
            valid_d  = 1'b0;
            halted_d = (branch_target >= DEPTH);
        end else if (!stall) begin
            if (halted_q) begin
                valid_d = 1'b0;
            end else begin
                instr_d = instruction;
                idpc_d  = pc_q;
                valid_d = 1'b1;
                count_d = count_q + 32'd1;
                // The last word parks the index instead of running off the end.
                if (pc_q == LAST_IDX) halted_d = 1'b1;
                else                  pc_d     = pc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            valid_q  <= 1'b0;
            instr_q  <= 32'd0;
            idpc_q   <= 32'd0;
            halted_q <= RST_HALTED;
            count_q  <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            idpc_q   <= idpc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign program_counter = pc_q;
    assign id_valid        = valid_q;
    assign id_instruction  = instr_q;
    assign id_pc           = idpc_q;
    assign halted          = halted_q;
    assign fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic [31:0] program_counter;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic        r2;
    logic [31:0] instr2, pc2, idi2, idpc2, cnt2;
    logic        v2, h2;
    int          xfer2 = 0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] idx);
        if (idx < 32'd4) return 32'hA000_0000 + idx;
        return 32'hBAD0_0000 ^ idx;
    endfunction

    assign instruction = memw(program_counter);
    assign instr2      = 32'hB000_0000 + pc2;

    fetch_stage #(.PC_RESET(32'd0), .MEM_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .branch_taken(branch_taken), .branch_target(branch_target), .id_ready(id_ready),
        .program_counter(program_counter), .id_valid(id_valid), .id_instruction(id_instruction),
        .id_pc(id_pc), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_stage dut2 (
        .clk(clk), .reset(r2), .instruction(instr2),
        .branch_taken(1'b0), .branch_target(32'd0), .id_ready(1'b1),
        .program_counter(pc2), .id_valid(v2), .id_instruction(idi2),
        .id_pc(idpc2), .halted(h2), .fetch_count(cnt2)
    );

    always @(posedge clk) if (!r2 && v2) xfer2 <= xfer2 + 1;

    // Behavioural model of the 4-word configuration, written from the priority rules.
    logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
    logic        m_valid, m_halted;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 0; m_valid <= 0; m_instr <= 0; m_idpc <= 0; m_halted <= 0; m_cnt <= 0;
        end else if (branch_taken) begin
            m_pc <= branch_target; m_valid <= 0; m_halted <= (branch_target >= 4);
        end else if (m_valid && !id_ready) begin
            m_pc <= m_pc;
        end else if (m_halted) begin
            m_valid <= 0;
        end else begin
            m_instr <= memw(m_pc);
            m_idpc  <= m_pc;
            m_valid <= 1;
            m_cnt   <= m_cnt + 1;
            if (m_pc == 3) m_halted <= 1;
            else           m_pc     <= m_pc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pc", program_counter, m_pc);
            chk("m_valid", {31'd0, id_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("m_instr", id_instruction, m_instr);
                chk("m_idpc", id_pc, m_idpc);
            end
            chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
            chk("m_cnt", fetch_count, m_cnt);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_word(input logic [31:0] idx, input logic [31:0] pc_exp,
                               input logic [31:0] cnt_exp);
        chk("valid", {31'd0, id_valid}, 32'd1);
        chk("instr", id_instruction, 32'hA000_0000 + idx);
        chk("id_pc", id_pc, idx);
        chk("pc", program_counter, pc_exp);
        chk("count", fetch_count, cnt_exp);
    endtask

    initial begin
        reset = 1'b1; r2 = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0; id_ready = 1'b1;
        #2;
        chk("rst_pc", program_counter, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instruction, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        tick();
        reset = 1'b0; r2 = 1'b0; chk_en = 1'b1;

        // Straight-line run through all four words, then halt.
        tick(); expect_word(0, 1, 1);
        tick(); expect_word(1, 2, 2);
        tick(); expect_word(2, 3, 3);
        tick(); expect_word(3, 3, 4);
        chk("halt_after_last", {31'd0, halted}, 32'd1);
        tick();
        chk("idle_valid", {31'd0, id_valid}, 32'd0);
        chk("idle_pc", program_counter, 32'd3);
        chk("idle_count", fetch_count, 32'd4);

        // Default-depth instance: exactly two transfers then halt.
        chk("d2_xfer", 32'(xfer2), 32'd2);
        chk("d2_count", cnt2, 32'd2);
        chk("d2_pc", pc2, 32'd1);
        chk("d2_halted", {31'd0, h2}, 32'd1);

        branch_taken = 1'b1; branch_target = 32'd0;
        tick(); branch_taken = 1'b0;
        chk("br0_valid", {31'd0, id_valid}, 32'd0);
        chk("br0_halted", {31'd0, halted}, 32'd0);
        tick(); expect_word(0, 1, 5);
        tick(); expect_word(1, 2, 6);

        // Stall three cycles holding A1.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_word(1, 2, 6);
        end
        id_ready = 1'b1;
        tick(); expect_word(2, 3, 7);

        branch_taken = 1'b1; branch_target = 32'd0;
        tick(); branch_taken = 1'b0;
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_pc", program_counter, 32'd0);
        tick(); expect_word(0, 1, 8);

        // Out-of-range redirect halts; in-range redirect resumes.
        branch_taken = 1'b1; branch_target = 32'd7;
        tick(); branch_taken = 1'b0;
        chk("oor_halted", {31'd0, halted}, 32'd1);
        chk("oor_pc", program_counter, 32'd7);
        tick(); tick();
        chk("oor_idle_valid", {31'd0, id_valid}, 32'd0);
        chk("oor_idle_count", fetch_count, 32'd8);
        branch_taken = 1'b1; branch_target = 32'd1;
        tick(); branch_taken = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        tick(); expect_word(1, 2, 9);

        // Branch while stalled drops the word; empty pipe fetches despite id_ready=0.
        id_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'd3;
        tick(); branch_taken = 1'b0;
        chk("bstall_valid", {31'd0, id_valid}, 32'd0);
        tick(); expect_word(3, 3, 10);
        id_ready = 1'b1;

        branch_taken = 1'b1; branch_target = 32'd0;
        tick(); branch_taken = 1'b0;
        tick(); expect_word(0, 1, 11);
        tick(); expect_word(1, 2, 12);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        chk("async_pc", program_counter, 32'd0);
        chk("async_valid", {31'd0, id_valid}, 32'd0);
        chk("async_count", fetch_count, 32'd0);
        chk("async_instr", id_instruction, 32'd0);
        tick(); reset = 1'b0;
        tick(); expect_word(0, 1, 1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            reset = ($urandom_range(0, 99) == 0);
            id_ready = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 6));
        end
        @(negedge clk); #1;
        reset = 1'b0; branch_taken = 1'b0;
        tick(); tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
